// File: rtl/coherent_dcache_ctrl_if.sv
// Signal bundle between one core, its coherent L1 data-cache controller and memory_control.
interface coherent_dcache_ctrl_if;
    logic        dmemREN;
    logic        dmemWEN;
    logic [31:0] dmemaddr;
    logic [31:0] dmemstore;
    logic [31:0] dmemload;
    logic        dhit;
    logic        dREN;
    logic        dWEN;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic [31:0] dload;
    logic        dwait;
    logic        cctrans;
    logic        ccwrite;
    logic        ccwait;
    logic        ccinv;
    logic [31:0] ccsnoopaddr;

    // Handshakes: the core holds dmemREN/dmemWEN (and address/data) until the cycle dhit is high;
    // the cache holds dREN/dWEN/daddr/dstore until an edge where dwait is low (transfer accepted);
    // memory_control holds ccwait high for the duration of a snoop and ccinv/ccsnoopaddr with it.
    modport master (
        input  dmemREN, dmemWEN, dmemaddr, dmemstore, dload, dwait, ccwait, ccinv, ccsnoopaddr,
        output dmemload, dhit, dREN, dWEN, daddr, dstore, cctrans, ccwrite
    );
    modport slave (
        output dmemREN, dmemWEN, dmemaddr, dmemstore, dload, dwait, ccwait, ccinv, ccsnoopaddr,
        input  dmemload, dhit, dREN, dWEN, daddr, dstore, cctrans, ccwrite
    );
endinterface

// File: rtl/coherent_dcache_ctrl.sv
// Direct-mapped, one-word-per-line MSI L1 data-cache controller for one core.
// Optional hit/miss counters are enabled with the DCACHE_HITCOUNT_EN macro.
module coherent_dcache_ctrl #(
    parameter int SETS  = 16,
    parameter int CPUID = 0
) (
    input  logic                   CLK,
    input  logic                   nRST,
    coherent_dcache_ctrl_if.master bus,
    output logic [2:0]             state_dbg,
    output logic [7:0]             cpuid_dbg
`ifdef DCACHE_HITCOUNT_EN
    ,
    output logic [31:0]            hitcount,
    output logic [31:0]            misscount
`endif
);
    localparam int IDXW = $clog2(SETS);
    localparam int TAGW = 30 - IDXW;

    typedef enum logic [2:0] {IDLE, EVICT, FETCH, SNOOP, SNOOP_WB} state_t;
    typedef enum logic [1:0] {LN_I, LN_S, LN_M} line_t;

    state_t          state, next_state;
    line_t           ln_st   [SETS];
    logic [TAGW-1:0] ln_tag  [SETS];
    logic [31:0]     ln_data [SETS];

    logic [IDXW-1:0] req_idx, snp_idx, upd_idx;
    logic [TAGW-1:0] req_tag, snp_tag;
    logic            req_any, req_wr, req_hit, snp_hit;
    logic            st_we, tag_we, data_we;
    line_t           upd_st;
    logic [31:0]     upd_data;
    logic            unused_addr_lsbs;

    assign req_idx = bus.dmemaddr[2+IDXW-1:2];
    assign req_tag = bus.dmemaddr[31:2+IDXW];
    assign snp_idx = bus.ccsnoopaddr[2+IDXW-1:2];
    assign snp_tag = bus.ccsnoopaddr[31:2+IDXW];
    assign req_wr  = bus.dmemWEN;
    assign req_any = bus.dmemREN | bus.dmemWEN;
    assign req_hit = (ln_st[req_idx] != LN_I) && (ln_tag[req_idx] == req_tag);
    assign snp_hit = (ln_st[snp_idx] != LN_I) && (ln_tag[snp_idx] == snp_tag);

    assign unused_addr_lsbs = ^{bus.dmemaddr[1:0], bus.ccsnoopaddr[1:0]};
    assign state_dbg        = state;
    assign cpuid_dbg        = 8'(CPUID);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= IDLE;
            for (int i = 0; i < SETS; i++) ln_st[i] <= LN_I;
        end else begin
            state <= next_state;
            if (st_we) ln_st[upd_idx] <= upd_st;
        end
    end

    // Tag and data carry no reset: a line in I is never read for a hit.
    always_ff @(posedge CLK) begin
        if (tag_we)  ln_tag[upd_idx]  <= req_tag;
        if (data_we) ln_data[upd_idx] <= upd_data;
    end

    always_comb begin
        next_state   = state;
        bus.dhit     = 1'b0;
        bus.dmemload = 32'h0;
        bus.dREN     = 1'b0;
        bus.dWEN     = 1'b0;
        bus.daddr    = 32'h0;
        bus.dstore   = 32'h0;
        bus.cctrans  = 1'b0;
        bus.ccwrite  = 1'b0;
        st_we        = 1'b0;
        tag_we       = 1'b0;
        data_we      = 1'b0;
        upd_idx      = req_idx;
        upd_st       = LN_I;
        upd_data     = bus.dmemstore;
        case (state)
            IDLE: begin
                if (bus.ccwait) begin
                    next_state = SNOOP;
                end else if (req_any) begin
                    if (req_hit && !req_wr) begin
                        bus.dhit     = 1'b1;
                        bus.dmemload = ln_data[req_idx];
                    end else if (req_hit && ln_st[req_idx] == LN_M) begin
                        bus.dhit = 1'b1;
                        data_we  = 1'b1;
                    end else if (req_hit || ln_st[req_idx] != LN_M) begin
                        // Upgrade from S, or a miss whose victim is clean.
                        next_state = FETCH;
                    end else begin
                        next_state = EVICT;
                    end
                end
            end
            EVICT: begin
                bus.dWEN   = 1'b1;
                bus.daddr  = {ln_tag[req_idx], req_idx, 2'b00};
                bus.dstore = ln_data[req_idx];
                if (!bus.dwait) begin
                    st_we      = 1'b1;
                    upd_st     = LN_I;
                    next_state = FETCH;
                end
            end
            FETCH: begin
                bus.cctrans = 1'b1;
                bus.dREN    = 1'b1;
                bus.ccwrite = req_wr;
                bus.daddr   = {bus.dmemaddr[31:2], 2'b00};
                if (!bus.dwait) begin
                    st_we      = 1'b1;
                    tag_we     = 1'b1;
                    data_we    = 1'b1;
                    upd_st     = req_wr ? LN_M : LN_S;
                    upd_data   = req_wr ? bus.dmemstore : bus.dload;
                    next_state = IDLE;
                end
            end
            SNOOP: begin
                upd_idx = snp_idx;
                if (snp_hit && ln_st[snp_idx] == LN_M) begin
                    next_state = SNOOP_WB;
                end else begin
                    if (snp_hit && bus.ccinv) begin
                        st_we  = 1'b1;
                        upd_st = LN_I;
                    end
                    if (!bus.ccwait) next_state = IDLE;
                end
            end
            SNOOP_WB: begin
                upd_idx    = snp_idx;
                bus.dWEN   = 1'b1;
                bus.daddr  = {bus.ccsnoopaddr[31:2], 2'b00};
                bus.dstore = ln_data[snp_idx];
                if (!bus.dwait) begin
                    st_we      = 1'b1;
                    upd_st     = bus.ccinv ? LN_I : LN_S;
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

`ifdef DCACHE_HITCOUNT_EN
    // after_fill marks the IDLE cycle whose dhit is the completion of a fill, not a pure hit.
    logic after_fill;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            hitcount   <= 32'h0;
            misscount  <= 32'h0;
            after_fill <= 1'b0;
        end else begin
            if (bus.dhit && !after_fill) hitcount <= hitcount + 32'd1;
            if (next_state == FETCH && state != FETCH) misscount <= misscount + 32'd1;
            if (state == FETCH && !bus.dwait) after_fill <= 1'b1;
            else if (state == IDLE && !bus.ccwait) after_fill <= 1'b0;
        end
    end
`endif
endmodule
